// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: shares bus 1 (requester A) and bus 2 (requester B) for drive/latch register moves
module reg_bus_sequencer #(
    parameter int IDX_W = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  a_req,
    input  logic [IDX_W-1:0]      a_src,
    input  logic [IDX_W-1:0]      a_dst,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic [IDX_W-1:0]      b_src,
    input  logic [IDX_W-1:0]      b_dst,
    output logic                  b_ack,
    output logic [2**IDX_W-1:0]   store,
    output logic [2**IDX_W-1:0]   store2,
    output logic [2**IDX_W-1:0]   load,
    output logic [2**IDX_W-1:0]   load2,
    output logic                  busy
);
    localparam int NREGS = 2**IDX_W;
    localparam logic [NREGS-1:0] ONE = 1;
    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, NOP} state_t;
    state_t state;
    logic prio, ga, gb, ra, rb;
    logic [IDX_W-1:0] ad, bd;
    logic conflict, ga_n, gb_n, ra_n, rb_n;
    always_comb begin
        conflict = a_req && b_req && (a_dst == b_dst);
        ga_n = a_req && !(conflict && prio);
        gb_n = b_req && !(conflict && !prio);
        ra_n = ga_n && (a_src != a_dst);
        rb_n = gb_n && (b_src != b_dst);
    end
    assign busy = state != IDLE;
    // prio = 0 favours A, 1 favours B; it flips to the loser after each conflict
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            prio   <= 1'b0;
            {ga, gb, ra, rb} <= '0;
            ad     <= '0;
            bd     <= '0;
            store  <= '0;
            store2 <= '0;
            load   <= '0;
            load2  <= '0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (a_req || b_req) begin
                    ga     <= ga_n;
                    gb     <= gb_n;
                    ra     <= ra_n;
                    rb     <= rb_n;
                    ad     <= a_dst;
                    bd     <= b_dst;
                    prio   <= conflict ? !prio : prio;
                    store  <= ra_n ? ONE << a_src : '0;
                    store2 <= rb_n ? ONE << b_src : '0;
                    a_ack  <= ga_n && !(ra_n || rb_n);
                    b_ack  <= gb_n && !(ra_n || rb_n);
                    state  <= (ra_n || rb_n) ? DRIVE : NOP;
                end
                DRIVE: begin
                    load  <= ra ? ONE << ad : '0;
                    load2 <= rb ? ONE << bd : '0;
                    a_ack <= ga;
                    b_ack <= gb;
                    state <= LATCH;
                end
                default: begin
                    store  <= '0;
                    store2 <= '0;
                    load   <= '0;
                    load2  <= '0;
                    a_ack  <= 1'b0;
                    b_ack  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer: vector table, corner sequences and randomized traffic against a cycle-expectation queue
module tb_reg_bus_sequencer;
    logic Clk = 1'b0, Reset = 1'b1;
    logic a_req = 1'b0, b_req = 1'b0;
    logic [2:0] a_src = '0, a_dst = '0, b_src = '0, b_dst = '0;
    logic a_ack, b_ack, busy;
    logic [7:0] store, store2, load, load2;
    int n_chk = 0, n_fail = 0, cyc = 0;

    reg_bus_sequencer dut (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_src(a_src), .a_dst(a_dst), .a_ack(a_ack),
        .b_req(b_req), .b_src(b_src), .b_dst(b_dst), .b_ack(b_ack),
        .store(store), .store2(store2), .load(load), .load2(load2), .busy(busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] store, store2, load, load2;
        logic a_ack, b_ack, busy;
    } exp_t;
    exp_t got, cur = '0;
    exp_t q[$];
    logic m_prio = 1'b0;
    assign got = {store, store2, load, load2, a_ack, b_ack, busy};

    // register bank driven by the strobes: loads take the pre-edge value driven onto their bus
    logic [7:0] bank [8];
    function automatic int idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'(8'h30 + i);
        end else begin
            if (|load) bank[idx(load)] <= bank[idx(store)];
            if (|load2) bank[idx(load2)] <= bank[idx(store2)];
        end
    end

    typedef struct {
        logic ar; logic [2:0] asrc, adst;
        logic br; logic [2:0] bsrc, bdst;
        logic nop;
        logic [7:0] s1, s2, l1, l2;
        logic ka, kb;
    } vec_t;
    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // expected outputs for the cycles following a grant, derived from the transfer rules
    task automatic model_grant();
        logic cf, ga, gb, ra, rb;
        exp_t d, l;
        if (!(a_req || b_req)) return;
        cf = a_req && b_req && a_dst == b_dst;
        ga = a_req && !(cf && m_prio);
        gb = b_req && !(cf && !m_prio);
        if (cf) m_prio = !m_prio;
        ra = ga && a_src != a_dst;
        rb = gb && b_src != b_dst;
        d = '0;
        d.busy = 1'b1;
        if (ra || rb) begin
            d.store  = ra ? 8'd1 << a_src : 8'd0;
            d.store2 = rb ? 8'd1 << b_src : 8'd0;
            l = d;
            l.load  = ra ? 8'd1 << a_dst : 8'd0;
            l.load2 = rb ? 8'd1 << b_dst : 8'd0;
            l.a_ack = ga;
            l.b_ack = gb;
            q.push_back(d);
            q.push_back(l);
        end else begin
            d.a_ack = ga;
            d.b_ack = gb;
            q.push_back(d);
        end
    endtask

    task automatic tick();
        logic bad;
        @(posedge Clk);
        cyc++;
        if (Reset) begin
            q.delete();
            m_prio = 1'b0;
        end else if (!cur.busy) model_grant();
        cur = '0;
        if (q.size() != 0) cur = q.pop_front();
        #1;
        check($sformatf("model cycle %0d", cyc), 32'(got), 32'(cur));
        bad = !$onehot0(store) || !$onehot0(store2) || !$onehot0(load) || !$onehot0(load2)
            || ((|load) && !(|store)) || ((|load2) && !(|store2)) || (|(load & load2));
        check($sformatf("invariants cycle %0d", cyc), 32'(bad), 32'd0);
    endtask

    initial begin
        vt[0] = '{1, 2, 5, 0, 0, 0, 0, 8'h04, 8'h00, 8'h20, 8'h00, 1, 0};
        vt[1] = '{1, 1, 3, 1, 4, 6, 0, 8'h02, 8'h10, 8'h08, 8'h40, 1, 1};
        vt[2] = '{1, 4, 4, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0};
        vt[3] = '{0, 0, 0, 1, 6, 0, 0, 8'h00, 8'h40, 8'h00, 8'h01, 0, 1};
        vt[4] = '{1, 3, 3, 1, 5, 1, 0, 8'h00, 8'h20, 8'h00, 8'h02, 1, 1};
        vt[5] = '{1, 7, 0, 1, 7, 1, 0, 8'h80, 8'h80, 8'h01, 8'h02, 1, 1};
        vt[6] = '{1, 2, 2, 1, 6, 6, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1};
        repeat (2) tick();
        check("reset outputs", 32'(got), 32'd0);
        Reset = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            {a_req, a_src, a_dst} = {vt[i].ar, vt[i].asrc, vt[i].adst};
            {b_req, b_src, b_dst} = {vt[i].br, vt[i].bsrc, vt[i].bdst};
            tick();
            check($sformatf("v%0d first store", i), {store, store2}, {vt[i].s1, vt[i].s2});
            check($sformatf("v%0d first load", i), {load, load2}, 16'd0);
            check($sformatf("v%0d first ack", i), {a_ack, b_ack, busy},
                  vt[i].nop ? {vt[i].ka, vt[i].kb, 1'b1} : 3'b001);
            a_req = 1'b0;
            b_req = 1'b0;
            if (!vt[i].nop) begin
                tick();
                check($sformatf("v%0d latch strobes", i), {store, store2, load, load2},
                      {vt[i].s1, vt[i].s2, vt[i].l1, vt[i].l2});
                check($sformatf("v%0d latch ack", i), {a_ack, b_ack, busy}, {vt[i].ka, vt[i].kb, 1'b1});
            end
            tick();
            check($sformatf("v%0d idle", i), 32'(got), 32'd0);
        end

        begin : swap
            logic [7:0] o1, o2;
            o1 = bank[1];
            o2 = bank[2];
            {a_req, a_src, a_dst, b_req, b_src, b_dst} = {1'b1, 3'd1, 3'd2, 1'b1, 3'd2, 3'd1};
            tick();
            a_req = 1'b0;
            b_req = 1'b0;
            repeat (2) tick();
            check("swap reg1", bank[1], o2);
            check("swap reg2", bank[2], o1);
        end

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        {a_req, a_src, a_dst, b_req, b_src, b_dst} = {1'b1, 3'd0, 3'd7, 1'b1, 3'd3, 3'd7};
        tick();
        check("conflict A drive", {store, store2}, 16'h0100);
        tick();
        check("conflict A latch", {load, load2, a_ack, b_ack}, {8'h80, 8'h00, 2'b10});
        tick();
        check("conflict idle gap", 32'(busy), 32'd0);
        tick();
        check("conflict B drive", {store, store2}, 16'h0008);
        tick();
        check("conflict B latch", {load, load2, a_ack, b_ack}, {8'h00, 8'h80, 2'b01});
        a_req = 1'b0;
        b_req = 1'b0;
        tick();

        {a_req, a_src, a_dst} = {1'b1, 3'd2, 3'd3};
        tick();
        check("pre-reset drive", store, 8'h04);
        Reset = 1'b1;
        tick();
        check("reset mid-op", 32'(got), 32'd0);
        Reset = 1'b0;
        tick();
        check("reissue drive", {store, load, a_ack}, {8'h04, 8'h00, 1'b0});
        tick();
        check("reissue latch", {store, load, a_ack}, {8'h04, 8'h08, 1'b1});
        a_req = 1'b0;
        tick();

        for (int n = 0; n < 3000; n++) begin
            tick();
            Reset = ($urandom_range(0, 299) == 0);
            if (a_ack || !a_req) begin
                a_req = ($urandom_range(0, 2) != 0);
                a_src = 3'($urandom_range(0, 7));
                a_dst = 3'($urandom_range(0, 3));
            end
            if (b_ack || !b_req) begin
                b_req = ($urandom_range(0, 2) != 0);
                b_src = 3'($urandom_range(0, 7));
                b_dst = 3'($urandom_range(0, 3));
            end
        end
        Reset = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
